fxp_div: RTL and testbench

FXP_DIV -- requirements
Module: fxp_div

---
 rtl/fxp_div_pkg.sv | 27 ++
 rtl/fxp_div_if.sv | 24 ++
 rtl/fxp_sat.sv | 40 ++++
 rtl/fxp_div.sv | 143 ++++++++++++++
 tb/tb_fxp_div.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fxp_div_pkg.sv
// Shared state encoding and two's-complement helpers for the fxp_div divider.
package fxp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [31:0] max_pos(input int width);
        return (32'h1 << (width - 1)) - 32'h1;
    endfunction

    function automatic logic [31:0] max_neg(input int width);
        return 32'h1 << (width - 1);
    endfunction

    function automatic logic [31:0] negate(input logic [31:0] v);
        return ~v + 32'h1;
    endfunction

    // Callers sign-extend to 32 bits first; the most negative value comes back as its exact unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v);
        return v[31] ? negate(v) : v;
    endfunction

endpackage

// File: rtl/fxp_div_if.sv
// Valid/ready operand and result bundle between fxp_div and its neighbours.
interface fxp_div_if #(
    parameter int WIDTH = 16
);
    logic                    i_valid;
    logic                    o_ready;
    logic signed [WIDTH-1:0] i_num;
    logic signed [WIDTH-1:0] i_denom;
    logic                    o_valid;
    logic                    i_ready;
    logic signed [WIDTH-1:0] o_result;
    logic                    o_div_zero;
    logic                    o_overflow;

    modport slave (
        input  i_valid, i_num, i_denom, i_ready,
        output o_ready, o_valid, o_result, o_div_zero, o_overflow
    );

    modport master (
        output i_valid, i_num, i_denom, i_ready,
        input  o_ready, o_valid, o_result, o_div_zero, o_overflow
    );
endinterface

// File: rtl/fxp_sat.sv
// Combinational round-up, sign application and saturation of a quotient magnitude.
module fxp_sat
    import fxp_div_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MAGW  = 24
) (
    input  logic                    sign_i,
    input  logic [MAGW-1:0]         mag_i,
    input  logic                    rnd_i,
    output logic signed [WIDTH-1:0] result_o,
    output logic                    overflow_o
);
    localparam logic [31:0] MAXP = max_pos(WIDTH);
    localparam logic [31:0] MAXN = max_neg(WIDTH);

    logic [MAGW:0]      mag_r;
    logic [MAGW:0]      lim_pos;
    logic [MAGW:0]      lim_neg;
    logic [WIDTH-1:0]   neg_w;

    always_comb begin
        // One spare bit so a rounding carry out of the top is still seen as overflow.
        mag_r      = {1'b0, mag_i} + {{MAGW{1'b0}}, rnd_i};
        lim_pos    = {{(MAGW + 1 - WIDTH){1'b0}}, MAXP[WIDTH-1:0]};
        lim_neg    = {{(MAGW + 1 - WIDTH){1'b0}}, MAXN[WIDTH-1:0]};
        neg_w      = WIDTH'(negate(32'(mag_r[WIDTH-1:0])));
        result_o   = mag_r[WIDTH-1:0];
        overflow_o = 1'b0;
        if (!sign_i && (mag_r > lim_pos)) begin
            result_o   = MAXP[WIDTH-1:0];
            overflow_o = 1'b1;
        end else if (sign_i && (mag_r > lim_neg)) begin
            result_o   = MAXN[WIDTH-1:0];
            overflow_o = 1'b1;
        end else if (sign_i) begin
            result_o   = neg_w;
        end
    end
endmodule

// File: rtl/fxp_div.sv
// Signed fixed-point restoring divider, one quotient bit per clock.
// Define FXP_DIV_ROUND_EN for round-half-away-from-zero (one extra CALC cycle).
module fxp_div
    import fxp_div_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QBITS = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    fxp_div_if.slave   bus
);
`ifdef FXP_DIV_ROUND_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int MAGW = WIDTH + QBITS;
    localparam int QW   = MAGW + RB;
    localparam int RW   = WIDTH + 1;
    localparam int CW   = $clog2(QW + 1);
    localparam logic [31:0] MAXP = max_pos(WIDTH);
    localparam logic [31:0] MAXN = max_neg(WIDTH);

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        den_q, den_d;
    logic [RW-1:0]           rem_q, rem_d;
    logic [QW-1:0]           quo_q, quo_d;
    logic                    sign_q, sign_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [WIDTH-1:0] result_q, result_d;
    logic                    dz_q, dz_d;
    logic                    ovf_q, ovf_d;

    logic [WIDTH-1:0]        num_mag, den_mag;
    logic [RW:0]             rem_sh, den_ext;
    logic                    q_bit;
    logic [QW-1:0]           quo_step;
    logic [MAGW-1:0]         sat_mag;
    logic                    sat_rnd;
    logic signed [WIDTH-1:0] sat_res;
    logic                    sat_ovf;

    assign num_mag  = WIDTH'(magnitude(32'(bus.i_num)));
    assign den_mag  = WIDTH'(magnitude(32'(bus.i_denom)));
    assign rem_sh   = {rem_q, quo_q[QW-1]};
    assign den_ext  = {2'b00, den_q};
    assign q_bit    = (rem_sh >= den_ext);
    assign quo_step = {quo_q[QW-2:0], q_bit};

`ifdef FXP_DIV_ROUND_EN
    assign sat_mag = quo_step[QW-1:1];
    assign sat_rnd = quo_step[0];
`else
    assign sat_mag = quo_step;
    assign sat_rnd = 1'b0;
`endif

    fxp_sat #(.WIDTH(WIDTH), .MAGW(MAGW)) u_sat (
        .sign_i     (sign_q),
        .mag_i      (sat_mag),
        .rnd_i      (sat_rnd),
        .result_o   (sat_res),
        .overflow_o (sat_ovf)
    );

    always_comb begin
        state_d  = state_q;
        den_d    = den_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    sign_d = bus.i_num[WIDTH-1] ^ bus.i_denom[WIDTH-1];
                    den_d  = den_mag;
                    rem_d  = '0;
                    quo_d  = QW'(num_mag) << (QBITS + RB);
                    cnt_d  = '0;
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                    if (bus.i_denom == '0) begin
                        state_d  = DONE;
                        dz_d     = 1'b1;
                        ovf_d    = 1'b1;
                        result_d = bus.i_num[WIDTH-1] ? MAXN[WIDTH-1:0] : MAXP[WIDTH-1:0];
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = q_bit ? RW'(rem_sh - den_ext) : RW'(rem_sh);
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(QW - 1)) begin
                    state_d  = DONE;
                    result_d = sat_res;
                    ovf_d    = sat_ovf;
                end
            end
            DONE: begin
                if (bus.i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            den_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            den_q    <= den_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.o_ready    = (state_q == IDLE);
    assign bus.o_valid    = (state_q == DONE);
    assign bus.o_result   = result_q;
    assign bus.o_div_zero = dz_q;
    assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_fxp_div.sv
// Directed-vector bench for fxp_div at WIDTH=16, QBITS=8 (honours FXP_DIV_ROUND_EN).
module tb_fxp_div;
    localparam int WIDTH = 16;
    localparam int QBITS = 8;
`ifdef FXP_DIV_ROUND_EN
    localparam int LAT = WIDTH + QBITS + 2;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = WIDTH + QBITS + 1;
    localparam bit RND = 1'b0;
`endif
    localparam int NV = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fxp_div_if #(.WIDTH(WIDTH)) bus ();

    fxp_div #(.WIDTH(WIDTH), .QBITS(QBITS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] num;
        logic [15:0] den;
        logic [15:0] res;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t tbl [NV];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operand pair, scramble the operand inputs after the accept edge, wait for o_valid.
    task automatic run_op(input logic [15:0] num, input logic [15:0] den,
                          output logic [15:0] res, output logic dz, output logic ov,
                          output int cyc);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_num   = num;
        bus.i_denom = den;
        bus.i_ready = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            bus.i_valid = 1'b0;
            bus.i_num   = ~num;
            bus.i_denom = num;
        end while (!bus.o_valid && cyc < 200);
        res = $unsigned(bus.o_result);
        dz  = bus.o_div_zero;
        ov  = bus.o_overflow;
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " o_ready"},    bus.o_ready,    1);
        check({tag, " o_valid"},    bus.o_valid,    0);
        check({tag, " o_result"},   $unsigned(bus.o_result), 0);
        check({tag, " o_div_zero"}, bus.o_div_zero, 0);
        check({tag, " o_overflow"}, bus.o_overflow, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r;
        logic        dz, ov;
        int          cyc;
        int          vcount;

        tbl[0]  = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0};
        tbl[1]  = '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0};
        tbl[2]  = '{16'h0200, 16'h0300, RND ? 16'h00AB : 16'h00AA, 1'b0, 1'b0};
        tbl[3]  = '{16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b1};
        tbl[4]  = '{16'hFF00, 16'h0000, 16'h8000, 1'b1, 1'b1};
        tbl[5]  = '{16'h7F00, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
        tbl[6]  = '{16'h8000, 16'hFF00, 16'h7FFF, 1'b0, 1'b1};
        tbl[7]  = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0};
        tbl[8]  = '{16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0};
        tbl[9]  = '{16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0};
        tbl[10] = '{16'hFFFE, 16'h0003, RND ? 16'hFF55 : 16'hFF56, 1'b0, 1'b0};
        tbl[11] = '{16'h0500, 16'h0400, 16'h0140, 1'b0, 1'b0};
        tbl[12] = '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1};

        bus.i_valid = 1'b0;
        bus.i_num   = '0;
        bus.i_denom = '0;
        bus.i_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].num, tbl[i].den, r, dz, ov, cyc);
            check($sformatf("v%0d result", i),   r,   tbl[i].res);
            check($sformatf("v%0d div_zero", i), dz,  tbl[i].dz);
            check($sformatf("v%0d overflow", i), ov,  tbl[i].ov);
            check($sformatf("v%0d latency", i),  cyc, tbl[i].dz ? 1 : LAT);
            release_result();
            check($sformatf("v%0d o_valid after release", i), bus.o_valid, 0);
            check($sformatf("v%0d o_ready after release", i), bus.o_ready, 1);
        end

        // Result must hold in DONE under back-pressure while a new request is ignored.
        run_op(16'h0300, 16'h0200, r, dz, ov, cyc);
        check("hold first result", r, 16'h0180);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.i_num   = 16'h0100;
            bus.i_denom = 16'h0000;
            @(posedge clk);
            #1;
            check($sformatf("hold%0d o_valid", k),    bus.o_valid, 1);
            check($sformatf("hold%0d o_result", k),   $unsigned(bus.o_result), 16'h0180);
            check($sformatf("hold%0d o_div_zero", k), bus.o_div_zero, 0);
            check($sformatf("hold%0d o_ready", k),    bus.o_ready, 0);
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        check("hold release o_valid", bus.o_valid, 0);
        check("hold release o_ready", bus.o_ready, 1);
        vcount = 0;
        repeat (LAT + 5) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) vcount++;
        end
        check("ignored request produced no result", vcount, 0);

        // Reset in the middle of CALC aborts the operation.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_num   = 16'h7F00;
        bus.i_denom = 16'h0001;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midcalc reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("held reset");
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        repeat (LAT + 5) begin
            @(posedge clk);
            #1;
            if (bus.o_valid) vcount++;
        end
        check("aborted op produced no result", vcount, 0);
        run_op(16'h0500, 16'h0400, r, dz, ov, cyc);
        check("post-reset result",   r,   16'h0140);
        check("post-reset div_zero", dz,  0);
        check("post-reset overflow", ov,  0);
        check("post-reset latency",  cyc, LAT);
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
